// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/exec/mem sequencer owning the PC and instruction register
module pc_sequencer #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] START_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [PC_W-1:0] start_addr_i,
  input  logic [7:0]      instr_i,
  input  logic            branchf_i,
  input  logic            branchb_i,
  input  logic [PC_W-1:0] offset_i,
  input  logic            memread_i,
  input  logic            memwrite_i,
  input  logic            done_i,
  input  logic            mem_ack_i,
  output logic            mem_req_o,
  output logic [PC_W-1:0] pc_o,
  output logic [7:0]      instr_o,
  output logic            exec_en_o,
  output logic            busy_o,
  output logic            halted_o,
  output logic            error_o,
  output logic [15:0]     cycle_cnt_o
);
  localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic            error_q, error_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  assign busy_o      = state_q == FETCH || state_q == EXEC || state_q == MEM;
  assign halted_o    = state_q == HALT;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign error_o     = error_q;
  assign cycle_cnt_o = cnt_q;
  // next-state, PC update and the combinational commit/request strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    error_d   = error_q;
    wait_d    = wait_q;
    cnt_d     = (busy_o && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    exec_en_o = 1'b0;
    mem_req_o = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (start_i) begin
          state_d = FETCH;
          pc_d    = start_addr_i;
          error_d = 1'b0;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        instr_d = instr_i;
        state_d = EXEC;
      end
      EXEC: begin
        if (done_i) begin
          state_d = HALT;
        end else if (memread_i || memwrite_i) begin
          state_d = MEM;
          wait_d  = '0;
        end else begin
          exec_en_o = 1'b1;
          pc_d      = branchf_i ? pc_q + offset_i : branchb_i ? pc_q - offset_i : pc_q + 1'b1;
          state_d   = FETCH;
        end
      end
      MEM: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          exec_en_o = 1'b1;
          pc_d      = pc_q + 1'b1;
          state_d   = FETCH;
        end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      instr_q <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench with a program-level reference model of the sequencer
module tb_pc_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i, start_i, mem_ack_i = 1'b0;
  logic [7:0] start_addr_i, instr_i, offset_i, pc_o, instr_o;
  logic branchf_i, branchb_i, memread_i, memwrite_i, done_i;
  logic mem_req_o, exec_en_o, busy_o, halted_o, error_o;
  logic [15:0] cycle_cnt_o;
  logic [2:0] op;
  logic [7:0] rom [256];
  int lat [256];
  bit used [256];
  typedef struct packed {logic halt; logic [7:0] pc; logic [7:0] ins; logic [15:0] cnt; logic err;} ev_t;
  ev_t q [$];
  int checks = 0, fails = 0;
  pc_sequencer dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .instr_i(instr_i), .branchf_i(branchf_i), .branchb_i(branchb_i), .offset_i(offset_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i), .done_i(done_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .pc_o(pc_o), .instr_o(instr_o), .exec_en_o(exec_en_o),
    .busy_o(busy_o), .halted_o(halted_o), .error_o(error_o), .cycle_cnt_o(cycle_cnt_o)
  );
  // ROM and decoder: op 0-2 alu, 3 both branches, 4 fwd, 5 back, 6 load/store (bit4), 7 done
  assign instr_i    = rom[pc_o];
  assign op         = instr_o[7:5];
  assign branchf_i  = op == 3'd3 || op == 3'd4;
  assign branchb_i  = op == 3'd3 || op == 3'd5;
  assign memread_i  = op == 3'd6 && !instr_o[4];
  assign memwrite_i = op == 3'd6 && instr_o[4];
  assign done_i     = op == 3'd7;
  assign offset_i   = {4'b0, instr_o[3:0]};
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [7:0] nxt(input logic [7:0] pc, input logic [7:0] ins);
    logic [7:0] off;
    off = {4'b0, ins[3:0]};
    return (ins[7:5] == 3'd3 || ins[7:5] == 3'd4) ? pc + off : ins[7:5] == 3'd5 ? pc - off : pc + 8'd1;
  endfunction
  task automatic run_model(input logic [7:0] a);
    logic [7:0] pc, ins;
    int c;
    pc = a;
    c = 0;
    for (int s = 0; s < 300; s++) begin
      ins = rom[pc];
      if (ins[7:5] == 3'd7) begin
        q.push_back('{1'b1, pc, ins, 16'(c + 2), 1'b0});
        return;
      end
      if (ins[7:5] == 3'd6) begin
        if (lat[pc] > 15) begin
          q.push_back('{1'b1, pc, ins, 16'(c + 17), 1'b1});
          return;
        end
        q.push_back('{1'b0, pc, ins, 16'(c + 1 + lat[pc]), 1'b0});
        c += 2 + lat[pc];
        pc = pc + 8'd1;
      end else begin
        q.push_back('{1'b0, pc, ins, 16'(c + 1), 1'b0});
        c += 2;
        pc = nxt(pc, ins);
      end
    end
  endtask
  task automatic gen_prog(input logic [7:0] a, input int n);
    logic [7:0] pc, ins;
    bit term;
    foreach (used[i]) used[i] = 1'b0;
    pc = a;
    for (int s = 0; s <= n; s++) begin
      used[pc] = 1'b1;
      ins = 8'($urandom);
      if (s == n || $urandom_range(0, 15) == 0) ins[7:5] = 3'd7;
      else if (ins[7:5] == 3'd7) ins[7:5] = 3'd0;
      lat[pc] = $urandom_range(1, 17);
      term = ins[7:5] == 3'd7 || (ins[7:5] == 3'd6 && lat[pc] > 15);
      if (!term && used[nxt(pc, ins)]) begin
        ins = 8'hE0;
        for (int o = 1; o < 16; o++)
          if (ins == 8'hE0 && !used[8'(pc + 8'(o))]) ins = {4'h8, 4'(o)};
      end
      rom[pc] = ins;
      if (ins[7:5] == 3'd7 || (ins[7:5] == 3'd6 && lat[pc] > 15)) break;
      pc = nxt(pc, ins);
    end
  endtask
  // data memory: acks on the lat-th MEM cycle, random spurious acks outside MEM
  int mcnt = 0;
  always @(posedge clk) begin
    #1;
    mcnt = mem_req_o ? mcnt + 1 : 0;
    mem_ack_i = mem_req_o ? (mcnt == lat[pc_o]) : ($urandom_range(0, 3) == 0);
  end
  // monitor: every commit strobe and every entry into HALT consumes one expected event
  logic prev_h = 1'b0;
  always @(negedge clk) begin
    ev_t e, g;
    if (exec_en_o || (halted_o && !prev_h)) begin
      g = '{!exec_en_o, pc_o, instr_o, cycle_cnt_o, error_o};
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL event: unexpected halt=%0b pc=%0h instr=%0h cnt=%0d err=%0b", g.halt, g.pc, g.ins, g.cnt, g.err);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL event: got halt=%0b pc=%0h instr=%0h cnt=%0d err=%0b, expected halt=%0b pc=%0h instr=%0h cnt=%0d err=%0b",
                   g.halt, g.pc, g.ins, g.cnt, g.err, e.halt, e.pc, e.ins, e.cnt, e.err);
        end
      end
    end
    prev_h = halted_o;
  end
  task automatic run(input logic [7:0] a);
    logic [15:0] h;
    logic [7:0] hp;
    run_model(a);
    @(negedge clk);
    start_i = 1'b1;
    start_addr_i = a;
    @(negedge clk);
    start_i = 1'b0;
    chk("start pc", pc_o, a);
    chk("start cnt", cycle_cnt_o, 0);
    chk("start err", error_o, 0);
    chk("start busy", busy_o, 1);
    for (int n = 0; n < 3000 && !halted_o; n++) begin
      @(negedge clk);
      start_i = busy_o && $urandom_range(0, 5) == 0;
      start_addr_i = 8'($urandom);
    end
    start_i = 1'b0;
    chk("halted", halted_o, 1);
    h = cycle_cnt_o;
    hp = pc_o;
    repeat (3) @(negedge clk);
    chk("cnt frozen", cycle_cnt_o, h);
    chk("pc frozen", pc_o, hp);
    chk("queue drained", q.size(), 0);
    q.delete();
  endtask
  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    start_addr_i = '0;
    foreach (rom[i]) begin
      rom[i] = 8'hE0;
      lat[i] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst pc", pc_o, 0);
    chk("rst instr", instr_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst halted", halted_o, 0);
    chk("rst err", error_o, 0);
    chk("rst cnt", cycle_cnt_o, 0);
    chk("rst memreq", mem_req_o, 0);
    chk("rst exec_en", exec_en_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    rom[8'h10] = 8'h01; rom[8'h11] = 8'hE0;
    run(8'h10);
    rom[8'h20] = 8'h85; rom[8'h25] = 8'hE0;
    run(8'h20);
    rom[8'h01] = 8'hA3; rom[8'hFE] = 8'hE0;
    run(8'h01);
    rom[8'h50] = 8'h64; rom[8'h54] = 8'hE0;
    run(8'h50);
    rom[8'h30] = 8'hC0; lat[8'h30] = 3; rom[8'h31] = 8'hE0;
    run(8'h30);
    rom[8'h70] = 8'hD0; lat[8'h70] = 15; rom[8'h71] = 8'hE0;
    run(8'h70);
    rom[8'h30] = 8'hD0; lat[8'h30] = 16;
    run(8'h30);
    chk("timeout err", error_o, 1);
    rom[8'h40] = 8'hE0;
    run(8'h40);
    rom[8'h00] = 8'hE0;
    run(8'h00);
    repeat (30) begin
      logic [7:0] a;
      a = 8'($urandom);
      gen_prog(a, $urandom_range(3, 20));
      run(a);
    end
    rom[8'h60] = 8'hC0; lat[8'h60] = 99;
    @(negedge clk);
    start_i = 1'b1;
    start_addr_i = 8'h60;
    @(negedge clk);
    start_i = 1'b0;
    for (int n = 0; n < 20 && !mem_req_o; n++) @(negedge clk);
    chk("mem_req before reset", mem_req_o, 1);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst pc", pc_o, 0);
    chk("midrst memreq", mem_req_o, 0);
    chk("midrst busy", busy_o, 0);
    chk("midrst halted", halted_o, 0);
    chk("midrst cnt", cycle_cnt_o, 0);
    chk("midrst instr", instr_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    q.delete();
    rom[8'h10] = 8'h01; rom[8'h11] = 8'hE0;
    run(8'h10);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
